// File: rtl/rx_router_pkg.sv
// Shared constants and helpers for the receive channel router.
// Default parameters and a constant log2 helper for sizing.
package rx_router_pkg;

   localparam int MAX_CH = 8;
   localparam int SEL_W  = 3;

   localparam int DEF_NUM_CH    = 4;
   localparam int DEF_DATA_W    = 8;
   localparam int DEF_DEPTH     = 16;
   localparam int DEF_AF_THRESH = 12;
   localparam int DEF_CNT_W     = 8;

   // ceil(log2(v)), usable in constant expressions
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/rx_chan_fifo.sv
// One receive channel: register-array FIFO with occupancy,
// flush, sticky overflow flag and saturating drop counter.
module rx_chan_fifo
   import rx_router_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int AF_THRESH = DEF_AF_THRESH,
   parameter int CNT_W     = DEF_CNT_W,
   localparam int PW       = clog2(DEPTH),
   localparam int CW       = PW + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              rd_i,
   input  logic              flush_i,
   input  logic              clr_i,
   output logic [DATA_W-1:0] data_o,
   output logic              valid_o,
   output logic              empty_o,
   output logic              full_o,
   output logic              afull_o,
   output logic [CW-1:0]     count_o,
   output logic              ovf_o,
   output logic [CNT_W-1:0]  drop_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PW-1:0]     wptr_q, wptr_d;
   logic [PW-1:0]     rptr_q, rptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [DATA_W-1:0] dout_q;
   logic              valid_q;
   logic              ovf_q, ovf_d;
   logic [CNT_W-1:0]  drop_q, drop_d;
   logic              is_full, is_empty;
   logic              do_wr, do_rd, drop;

   assign is_full  = (count_q == CW'(DEPTH));
   assign is_empty = (count_q == '0);

   // A read on a full channel frees the slot the write lands in
   assign do_rd = rd_i & ~is_empty & ~flush_i;
   assign do_wr = wr_i & ~flush_i & (~is_full | do_rd);
   assign drop  = wr_i & ~flush_i & is_full & ~do_rd;

   // Pointer/occupancy next state; flush overrides everything
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (flush_i) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (do_wr) wptr_d = wptr_q + 1'b1;
         if (do_rd) rptr_d = rptr_q + 1'b1;
         if (do_wr && !do_rd) count_d = count_q + 1'b1;
         else if (do_rd && !do_wr) count_d = count_q - 1'b1;
      end
   end

   // Error tracking: a drop in the clear cycle still registers
   always_comb begin
      ovf_d  = ovf_q;
      drop_d = drop_q;
      if (clr_i) begin
         ovf_d  = 1'b0;
         drop_d = '0;
      end
      if (drop) begin
         ovf_d = 1'b1;
         if (drop_d != '1) drop_d = drop_d + 1'b1;
      end
   end

   // Control and read-data registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
         drop_q  <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         valid_q <= do_rd;
         ovf_q   <= ovf_d;
         drop_q  <= drop_d;
         if (do_rd) dout_q <= mem_q[rptr_q];
      end
   end

   // Entry storage, no reset needed
   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wptr_q] <= data_i;
   end

   assign data_o  = dout_q;
   assign valid_o = valid_q;
   assign empty_o = is_empty;
   assign full_o  = is_full;
   assign afull_o = (count_q >= CW'(AF_THRESH));
   assign count_o = count_q;
   assign ovf_o   = ovf_q;
   assign drop_o  = drop_q;

endmodule

// File: rtl/rx_channel_router.sv
// Fans received bytes out to NUM_CH independent FIFO channels
// chosen by chan_sel, flagging writes to nonexistent channels.
module rx_channel_router
   import rx_router_pkg::*;
#(
   parameter int NUM_CH    = DEF_NUM_CH,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int AF_THRESH = DEF_AF_THRESH,
   parameter int CNT_W     = DEF_CNT_W,
   localparam int CW       = clog2(DEPTH) + 1
) (
   input  logic                     clk,
   input  logic                     SYS_reset,
   input  logic                     wr_valid,
   input  logic [DATA_W-1:0]        data_in,
   input  logic [SEL_W-1:0]         chan_sel,
   input  logic [NUM_CH-1:0]        rd_req,
   input  logic [NUM_CH-1:0]        flush,
   input  logic                     clr_err,
   output logic [NUM_CH*DATA_W-1:0] data_out,
   output logic [NUM_CH-1:0]        data_valid,
   output logic [NUM_CH-1:0]        empty,
   output logic [NUM_CH-1:0]        full,
   output logic [NUM_CH-1:0]        almost_full,
   output logic [NUM_CH*CW-1:0]     count,
   output logic [NUM_CH-1:0]        ovf,
   output logic [NUM_CH*CNT_W-1:0]  drop_cnt,
   output logic                     bad_sel
);

   localparam logic [SEL_W:0] NCH = (SEL_W + 1)'(NUM_CH);

   logic sel_ok;
   logic bad_q, bad_d;

   assign sel_ok = ({1'b0, chan_sel} < NCH);

   // Sticky bad-select flag; a bad write beats a clear
   always_comb begin
      bad_d = bad_q;
      if (clr_err) bad_d = 1'b0;
      if (wr_valid && !sel_ok) bad_d = 1'b1;
   end

   // Bad-select register
   always_ff @(posedge clk or negedge SYS_reset) begin
      if (!SYS_reset) bad_q <= 1'b0;
      else            bad_q <= bad_d;
   end

   assign bad_sel = bad_q;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      localparam logic [SEL_W-1:0] CID = SEL_W'(c);
      logic wr_c;

      assign wr_c = wr_valid & sel_ok & (chan_sel == CID);

      rx_chan_fifo #(
         .DATA_W    (DATA_W),
         .DEPTH     (DEPTH),
         .AF_THRESH (AF_THRESH),
         .CNT_W     (CNT_W)
      ) u_fifo (
         .clk     (clk),
         .rst_n   (SYS_reset),
         .wr_i    (wr_c),
         .data_i  (data_in),
         .rd_i    (rd_req[c]),
         .flush_i (flush[c]),
         .clr_i   (clr_err),
         .data_o  (data_out[c*DATA_W +: DATA_W]),
         .valid_o (data_valid[c]),
         .empty_o (empty[c]),
         .full_o  (full[c]),
         .afull_o (almost_full[c]),
         .count_o (count[c*CW +: CW]),
         .ovf_o   (ovf[c]),
         .drop_o  (drop_cnt[c*CNT_W +: CNT_W])
      );
   end

endmodule

// File: tb/tb_rx_channel_router.sv
// Directed scoreboard bench for rx_channel_router.
// Stimulus pushes expected bytes; a monitor pops on data_valid.
module tb_rx_channel_router;

   localparam int CW = 5;
   localparam int KW = 8;

   logic        clk = 1'b0;
   logic        SYS_reset;
   logic        wr_valid;
   logic [7:0]  data_in;
   logic [2:0]  chan_sel;
   logic [3:0]  rd_req;
   logic [3:0]  flush;
   logic        clr_err;
   logic [31:0] data_out;
   logic [3:0]  data_valid;
   logic [3:0]  empty;
   logic [3:0]  full;
   logic [3:0]  almost_full;
   logic [19:0] count;
   logic [3:0]  ovf;
   logic [31:0] drop_cnt;
   logic        bad_sel;

   int nvec    = 0;
   int nerr    = 0;
   int mon_n   = 0;
   int mon_err = 0;

   logic [7:0] exp_q [4][$];
   logic [7:0] mon_e;

   always #5 clk = ~clk;

   rx_channel_router #(
      .NUM_CH    (4),
      .DATA_W    (8),
      .DEPTH     (16),
      .AF_THRESH (12),
      .CNT_W     (8)
   ) dut (
      .clk         (clk),
      .SYS_reset   (SYS_reset),
      .wr_valid    (wr_valid),
      .data_in     (data_in),
      .chan_sel    (chan_sel),
      .rd_req      (rd_req),
      .flush       (flush),
      .clr_err     (clr_err),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .empty       (empty),
      .full        (full),
      .almost_full (almost_full),
      .count       (count),
      .ovf         (ovf),
      .drop_cnt    (drop_cnt),
      .bad_sel     (bad_sel)
   );

   function automatic logic [31:0] cnt(input int c);
      return 32'(count[c*CW +: CW]);
   endfunction

   function automatic logic [31:0] drp(input int c);
      return 32'(drop_cnt[c*KW +: KW]);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int ch, input logic [7:0] d, input bit acc);
      wr_valid = 1'b1;
      chan_sel = 3'(ch);
      data_in  = d;
      tick();
      wr_valid = 1'b0;
      if (acc) exp_q[ch].push_back(d);
   endtask

   task automatic rd(input int ch, input int n);
      rd_req[ch] = 1'b1;
      repeat (n) tick();
      rd_req[ch] = 1'b0;
   endtask

   // Monitor: every data_valid pulse must match the next expected byte
   initial begin
      forever begin
         @(posedge clk);
         #2;
         for (int c = 0; c < 4; c++) begin
            if (data_valid[c] === 1'b1) begin
               mon_n++;
               if (exp_q[c].size() == 0) begin
                  mon_err++;
                  $display("FAIL unexpected_pop ch%0d: got %0h, expected none",
                           c, data_out[c*8 +: 8]);
               end else begin
                  mon_e = exp_q[c].pop_front();
                  if (data_out[c*8 +: 8] !== mon_e) begin
                     mon_err++;
                     $display("FAIL pop_data ch%0d: got %0h, expected %0h",
                              c, data_out[c*8 +: 8], mon_e);
                  end
               end
            end
         end
      end
   end

   initial begin
      SYS_reset = 1'b0;
      wr_valid  = 1'b0;
      data_in   = '0;
      chan_sel  = '0;
      rd_req    = '0;
      flush     = '0;
      clr_err   = 1'b0;
      #2;
      chk("rst_empty", 32'(empty), 32'hf);
      chk("rst_count", 32'(count), 32'h0);
      chk("rst_full", 32'(full), 32'h0);
      chk("rst_valid", 32'(data_valid), 32'h0);
      chk("rst_ovf", 32'(ovf), 32'h0);
      chk("rst_drop", drop_cnt, 32'h0);
      chk("rst_bad", 32'(bad_sel), 32'h0);
      #10;
      SYS_reset = 1'b1;
      tick();

      // Reset in the middle of operation
      for (int i = 0; i < 5; i++) wr(0, 8'(8'h01 + i), 1'b1);
      chk("t1_cnt0", cnt(0), 32'd5);
      #2;
      SYS_reset = 1'b0;
      #1;
      chk("t1_count", 32'(count), 32'h0);
      chk("t1_empty", 32'(empty), 32'hf);
      chk("t1_valid", 32'(data_valid), 32'h0);
      exp_q[0].delete();
      #3;
      SYS_reset = 1'b1;
      tick();

      // Ordering on ch2
      wr(2, 8'h11, 1'b1);
      wr(2, 8'h22, 1'b1);
      wr(2, 8'h33, 1'b1);
      chk("t2_cnt2", cnt(2), 32'd3);
      rd(2, 4);
      chk("t2_empty2", 32'(empty[2]), 32'd1);
      chk("t2_cnt2_end", cnt(2), 32'd0);

      // Overflow on ch1
      for (int i = 0; i < 18; i++) begin
         wr(1, 8'(8'h40 + i), i < 16);
         if (i == 10) chk("t3_af_11", 32'(almost_full[1]), 32'd0);
         if (i == 11) chk("t3_af_12", 32'(almost_full[1]), 32'd1);
      end
      chk("t3_full1", 32'(full[1]), 32'd1);
      chk("t3_ovf1", 32'(ovf[1]), 32'd1);
      chk("t3_drop1", drp(1), 32'd2);
      chk("t3_cnt1", cnt(1), 32'd16);

      // Full channel with simultaneous read and write
      for (int i = 0; i < 16; i++) wr(3, 8'(8'h80 + i), 1'b1);
      chk("t4_full3", 32'(full[3]), 32'd1);
      wr_valid   = 1'b1;
      chan_sel   = 3'd3;
      rd_req[3]  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         data_in = 8'(8'hA0 + i);
         tick();
         exp_q[3].push_back(8'(8'hA0 + i));
         chk("t4_cnt3", cnt(3), 32'd16);
      end
      wr_valid  = 1'b0;
      rd_req[3] = 1'b0;
      chk("t4_ovf3", 32'(ovf[3]), 32'd0);
      chk("t4_drop3", drp(3), 32'd0);
      rd(3, 17);
      chk("t4_empty3", 32'(empty[3]), 32'd1);

      // Flush ch0 with same-cycle write and read
      for (int i = 0; i < 7; i++) wr(0, 8'(8'hC0 + i), 1'b1);
      chk("t6_cnt0", cnt(0), 32'd7);
      flush[0]  = 1'b1;
      wr_valid  = 1'b1;
      chan_sel  = 3'd0;
      data_in   = 8'hEE;
      rd_req[0] = 1'b1;
      tick();
      flush     = '0;
      wr_valid  = 1'b0;
      rd_req    = '0;
      exp_q[0].delete();
      chk("t6_cnt0_flush", cnt(0), 32'd0);
      chk("t6_empty0", 32'(empty[0]), 32'd1);
      chk("t6_valid0", 32'(data_valid[0]), 32'd0);
      chk("t6_cnt1", cnt(1), 32'd16);
      chk("t6_ovf1", 32'(ovf[1]), 32'd1);
      chk("t6_drop1", drp(1), 32'd2);
      rd(1, 17);
      chk("t6_empty1", 32'(empty[1]), 32'd1);
      chk("t6_ovf1_kept", 32'(ovf[1]), 32'd1);

      // Drop counter saturation, survives flush
      for (int i = 0; i < 16; i++) wr(2, 8'(8'h60 + i), 1'b0);
      for (int i = 0; i < 260; i++) wr(2, 8'hFF, 1'b0);
      chk("sat_drop2", drp(2), 32'd255);
      chk("sat_ovf2", 32'(ovf[2]), 32'd1);
      flush[2] = 1'b1;
      tick();
      flush[2] = 1'b0;
      chk("sat_cnt2", cnt(2), 32'd0);
      chk("sat_drop2_kept", drp(2), 32'd255);

      // Bad select and error clearing
      wr(0, 8'h5A, 1'b1);
      wr(5, 8'h55, 1'b0);
      chk("t5_bad", 32'(bad_sel), 32'd1);
      chk("t5_count", 32'(count), 32'h00001);
      clr_err  = 1'b1;
      wr(6, 8'h66, 1'b0);
      chk("t5_bad_wins", 32'(bad_sel), 32'd1);
      chk("t5_drop_clr", drp(2), 32'd0);
      for (int i = 0; i < 16; i++) wr(3, 8'(8'h90 + i), 1'b0);
      wr(3, 8'h9F, 1'b0);
      chk("t5_drop3_wins", drp(3), 32'd1);
      chk("t5_ovf3_wins", 32'(ovf[3]), 32'd1);
      flush[3] = 1'b1;
      tick();
      flush[3] = 1'b0;
      clr_err  = 1'b0;
      chk("t5_bad_clr", 32'(bad_sel), 32'd0);
      chk("t5_ovf_clr", 32'(ovf), 32'h0);
      chk("t5_drops_clr", drop_cnt, 32'h0);
      chk("t5_cnt0", cnt(0), 32'd1);
      rd(0, 2);
      tick();

      for (int c = 0; c < 4; c++) chk("left_in_q", 32'(exp_q[c].size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==",
               nvec + mon_n, nerr + mon_err);
      $finish;
   end

endmodule
